// File: rtl/return_address_stack_if.sv
`default_nettype none
// ============================================================================
// Module      : return_address_stack_if
// Description : Fetch / branch-unit side bundle of the return address stack.
//               master : driven by fetch and the branch unit
//               slave  : the return address stack itself
//   push, pop, new_addr       fetch call/return prediction and push value
//   branch_fetched            record a pointer checkpoint
//   branch_retired, flush     retire / restore the oldest checkpoint
//   addr, valid, track_full   prediction and checkpoint back-pressure
// Revision    : 1.0 - initial release
// ============================================================================
interface return_address_stack_if;
    logic        push;
    logic        pop;
    logic [31:0] new_addr;
    logic        branch_fetched;
    logic        branch_retired;
    logic        flush;
    logic [31:0] addr;
    logic        valid;
    logic        track_full;

    modport master (
        output push, pop, new_addr, branch_fetched, branch_retired, flush,
        input  addr, valid, track_full
    );

    modport slave (
        input  push, pop, new_addr, branch_fetched, branch_retired, flush,
        output addr, valid, track_full
    );
endinterface
`default_nettype wire

// File: rtl/return_address_stack.sv
`default_nettype none
// ============================================================================
// Module      : return_address_stack
// Description : Circular return address stack for the fetch-stage predictor.
//               Calls push, returns pop, call+return replaces the top entry.
//               With RAS_FLUSH_RECOVERY_EN defined, every predicted
//               instruction checkpoints {read_index, count} in a FIFO; a
//               flush restores the pointer from the oldest checkpoint.
//               Without the macro the checkpoint logic is absent and
//               track_full is tied low.
// Ports       : clk, rst (async, active-high)
//               bus : return_address_stack_if.slave
//                     (push, pop, new_addr, branch_fetched, branch_retired,
//                      flush in; addr, valid, track_full out)
// Parameters  : DEPTH       stack entries, power of two, >= 2
//               TRACK_DEPTH checkpoint FIFO depth, power of two
// Revision    : 1.0 - initial release
// ============================================================================
module return_address_stack #(
    parameter int DEPTH       = 8,
    parameter int TRACK_DEPTH = 8
) (
    input  wire logic               clk,
    input  wire logic               rst,
    return_address_stack_if.slave   bus
);

    localparam int c_IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CNT_W = $clog2(DEPTH + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(DEPTH);
    localparam logic [c_IDX_W-1:0] c_IDX_ONE = c_IDX_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);

    logic [31:0]        r_stack [DEPTH];
    logic [c_IDX_W-1:0] r_idx;
    logic [c_CNT_W-1:0] r_cnt;

    logic [c_IDX_W-1:0] w_idx_upd;
    logic [c_CNT_W-1:0] w_cnt_upd;
    logic [c_IDX_W-1:0] w_idx_nxt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic               w_wr_en;
    logic [c_IDX_W-1:0] w_wr_idx;
    logic               w_stack_we;
    logic               w_nonempty;

    assign w_nonempty = (r_cnt != '0);

    // Speculative push/pop update, before any flush override.
    always_comb begin
        w_idx_upd = r_idx;
        w_cnt_upd = r_cnt;
        w_wr_en   = 1'b0;
        w_wr_idx  = r_idx + c_IDX_ONE;
        if (bus.push && bus.pop && w_nonempty) begin
            // Return-and-call: the return consumes the top, the call
            // replaces it in place.
            w_wr_en  = 1'b1;
            w_wr_idx = r_idx;
        end else if (bus.push) begin
            w_idx_upd = r_idx + c_IDX_ONE;
            w_wr_en   = 1'b1;
            w_wr_idx  = r_idx + c_IDX_ONE;
            if (r_cnt != c_CNT_MAX) begin
                w_cnt_upd = r_cnt + c_CNT_ONE;
            end
        end else if (bus.pop && w_nonempty) begin
            w_idx_upd = r_idx - c_IDX_ONE;
            w_cnt_upd = r_cnt - c_CNT_ONE;
        end
    end

`ifdef RAS_FLUSH_RECOVERY_EN
    localparam int c_TRK_W = (TRACK_DEPTH > 1) ? $clog2(TRACK_DEPTH) : 1;
    localparam int c_OCC_W = $clog2(TRACK_DEPTH + 1);
    localparam logic [c_OCC_W-1:0] c_OCC_MAX  = c_OCC_W'(TRACK_DEPTH);
    localparam logic [c_OCC_W-1:0] c_OCC_ONE  = c_OCC_W'(1);
    localparam logic [c_TRK_W-1:0] c_PTR_LAST = c_TRK_W'(TRACK_DEPTH - 1);
    localparam logic [c_TRK_W-1:0] c_PTR_ONE  = c_TRK_W'(1);

    logic [c_IDX_W-1:0] r_ck_idx [TRACK_DEPTH];
    logic [c_CNT_W-1:0] r_ck_cnt [TRACK_DEPTH];
    logic [c_TRK_W-1:0] r_head;
    logic [c_TRK_W-1:0] r_tail;
    logic [c_OCC_W-1:0] r_occ;
    logic               r_track_full;

    logic               w_fetch;
    logic               w_retire;
    logic [c_OCC_W-1:0] w_occ_nxt;
    logic [c_TRK_W-1:0] w_head_inc;
    logic [c_TRK_W-1:0] w_tail_inc;

    // Flush overrides every other request in the same cycle.
    assign w_fetch  = bus.branch_fetched && !bus.flush && !r_track_full;
    assign w_retire = bus.branch_retired && !bus.flush && (r_occ != '0);

    assign w_head_inc = (r_head == c_PTR_LAST) ? '0 : r_head + c_PTR_ONE;
    assign w_tail_inc = (r_tail == c_PTR_LAST) ? '0 : r_tail + c_PTR_ONE;

    always_comb begin
        w_occ_nxt = r_occ;
        if (bus.flush) begin
            w_occ_nxt = '0;
        end else begin
            case ({w_fetch, w_retire})
                2'b10:   w_occ_nxt = r_occ + c_OCC_ONE;
                2'b01:   w_occ_nxt = r_occ - c_OCC_ONE;
                default: w_occ_nxt = r_occ;
            endcase
        end
    end

    // The head checkpoint belongs to the flushing instruction; with no
    // checkpoint outstanding the pointer simply holds.
    always_comb begin
        w_idx_nxt = w_idx_upd;
        w_cnt_nxt = w_cnt_upd;
        if (bus.flush) begin
            if (r_occ != '0) begin
                w_idx_nxt = r_ck_idx[r_head];
                w_cnt_nxt = r_ck_cnt[r_head];
            end else begin
                w_idx_nxt = r_idx;
                w_cnt_nxt = r_cnt;
            end
        end
    end

    assign w_stack_we = w_wr_en && !bus.flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head       <= '0;
            r_tail       <= '0;
            r_occ        <= '0;
            r_track_full <= 1'b0;
        end else begin
            if (bus.flush) begin
                r_head <= '0;
                r_tail <= '0;
            end else begin
                if (w_fetch) begin
                    r_tail <= w_tail_inc;
                end
                if (w_retire) begin
                    r_head <= w_head_inc;
                end
            end
            r_occ        <= w_occ_nxt;
            r_track_full <= (w_occ_nxt == c_OCC_MAX);
        end
    end

    // Checkpoint payload holds the post-update pointer of this cycle.
    always_ff @(posedge clk) begin
        if (w_fetch) begin
            r_ck_idx[r_tail] <= w_idx_upd;
            r_ck_cnt[r_tail] <= w_cnt_upd;
        end
    end

    assign bus.track_full = r_track_full;

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!rst) begin
            assert (!(bus.branch_fetched && !bus.flush && r_track_full))
                else $warning("branch_fetched dropped while track_full");
        end
    end
`endif
`else
    logic w_unused;

    assign w_unused       = ^{bus.branch_fetched, bus.branch_retired, bus.flush};
    assign w_idx_nxt      = w_idx_upd;
    assign w_cnt_nxt      = w_cnt_upd;
    assign w_stack_we     = w_wr_en;
    assign bus.track_full = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx <= '0;
            r_cnt <= '0;
        end else begin
            r_idx <= w_idx_nxt;
            r_cnt <= w_cnt_nxt;
        end
    end

    // Stack storage is not reset; count gates its visibility.
    always_ff @(posedge clk) begin
        if (w_stack_we) begin
            r_stack[w_wr_idx] <= bus.new_addr;
        end
    end

    assign bus.addr  = w_nonempty ? r_stack[r_idx] : 32'd0;
    assign bus.valid = w_nonempty;

endmodule
`default_nettype wire

// File: tb/tb_return_address_stack.sv
`default_nettype none
// ============================================================================
// Module      : tb_return_address_stack
// Description : Directed table-driven bench for return_address_stack plus
//               hand sequences for reset, flush restore and track_full.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_return_address_stack;

`ifdef RAS_FLUSH_RECOVERY_EN
    localparam bit c_REC = 1'b1;
`else
    localparam bit c_REC = 1'b0;
`endif

    typedef struct {
        logic        push;
        logic        pop;
        logic [31:0] new_addr;
        logic [31:0] exp_addr;
        logic        exp_valid;
    } vec_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    return_address_stack_if bus_if ();

    return_address_stack #(
        .DEPTH       (8),
        .TRACK_DEPTH (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    int   n_vec = 0;
    int   n_err = 0;
    vec_t tbl [64];
    int   n_tbl = 0;

    task automatic add(input logic p, input logic q, input logic [31:0] a,
                       input logic [31:0] ea, input logic ev);
        tbl[n_tbl].push      = p;
        tbl[n_tbl].pop       = q;
        tbl[n_tbl].new_addr  = a;
        tbl[n_tbl].exp_addr  = ea;
        tbl[n_tbl].exp_valid = ev;
        n_tbl++;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [31:0] ea, input logic ev, input logic ef);
        check({tag, " addr"},       bus_if.addr,                 ea);
        check({tag, " valid"},      {31'd0, bus_if.valid},       {31'd0, ev});
        check({tag, " track_full"}, {31'd0, bus_if.track_full},  {31'd0, ef});
    endtask

    task automatic idle();
        bus_if.push           = 1'b0;
        bus_if.pop            = 1'b0;
        bus_if.new_addr       = 32'd0;
        bus_if.branch_fetched = 1'b0;
        bus_if.branch_retired = 1'b0;
        bus_if.flush          = 1'b0;
    endtask

    // One clock with the given request; returns 1 time unit after the edge.
    task automatic step(input logic p, input logic q, input logic [31:0] a,
                        input logic f, input logic r, input logic fl);
        @(negedge clk);
        bus_if.push           = p;
        bus_if.pop            = q;
        bus_if.new_addr       = a;
        bus_if.branch_fetched = f;
        bus_if.branch_retired = r;
        bus_if.flush          = fl;
        @(posedge clk);
        #1;
        idle();
    endtask

    // Reset raised between clock edges; outputs must clear before any edge.
    task automatic async_reset(input string tag);
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check_out(tag, 32'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idle();

        // Basic push/pop, underflow, return-and-call.
        add(1, 0, 32'h100, 32'h100, 1);
        add(1, 0, 32'h200, 32'h200, 1);
        add(0, 1, 32'h0,   32'h100, 1);
        add(0, 1, 32'h0,   32'h0,   0);
        add(0, 1, 32'h0,   32'h0,   0);
        add(1, 0, 32'h50,  32'h50,  1);
        add(1, 0, 32'h60,  32'h60,  1);
        add(1, 1, 32'h100, 32'h100, 1);
        add(0, 1, 32'h0,   32'h50,  1);
        add(0, 1, 32'h0,   32'h0,   0);
        add(1, 1, 32'h77,  32'h77,  1);
        add(0, 1, 32'h0,   32'h0,   0);
        // Overflow: nine pushes into eight entries, 0x10 is lost.
        for (int i = 1; i <= 9; i++) begin
            add(1, 0, 32'(i * 16), 32'(i * 16), 1);
        end
        for (int j = 1; j <= 7; j++) begin
            add(0, 1, 32'h0, 32'((9 - j) * 16), 1);
        end
        add(0, 1, 32'h0, 32'h0, 0);

        repeat (2) @(negedge clk);
        check_out("reset", 32'd0, 1'b0, 1'b0);
        rst = 1'b0;

        for (int i = 0; i < n_tbl; i++) begin
            step(tbl[i].push, tbl[i].pop, tbl[i].new_addr, 1'b0, 1'b0, 1'b0);
            check_out($sformatf("vec%0d", i), tbl[i].exp_addr, tbl[i].exp_valid, 1'b0);
        end

        // Reset in the middle of operation.
        step(1, 0, 32'hAA, 0, 0, 0);
        check_out("pre_rst", 32'hAA, 1'b1, 1'b0);
        async_reset("async_rst");

        // Flush restores the first checkpoint {1,1}.
        step(1, 0, 32'h100, 1, 0, 0);
        check_out("ck_push1", 32'h100, 1'b1, 1'b0);
        step(1, 0, 32'h200, 1, 0, 0);
        step(1, 0, 32'h300, 1, 0, 0);
        check_out("ck_push3", 32'h300, 1'b1, 1'b0);
        step(0, 0, 32'h0, 0, 0, 1);
        check_out("flush", c_REC ? 32'h100 : 32'h300, 1'b1, 1'b0);
        step(0, 0, 32'h0, 0, 0, 1);
        check_out("flush_empty", c_REC ? 32'h100 : 32'h300, 1'b1, 1'b0);
        step(0, 1, 32'h0, 0, 0, 0);
        check_out("flush_pop", c_REC ? 32'h0 : 32'h200, !c_REC, 1'b0);
        async_reset("rst2");

        // Checkpoint FIFO fill, dropped request, retire.
        for (int k = 1; k <= 8; k++) begin
            step(0, 0, 32'h0, 1, 0, 0);
            if (k >= 7) begin
                check($sformatf("fill%0d track_full", k), {31'd0, bus_if.track_full},
                      {31'd0, (k == 8) ? c_REC : 1'b0});
            end
        end
        step(0, 0, 32'h0, 1, 0, 0);
        check_out("drop9", 32'd0, 1'b0, c_REC);
        step(0, 0, 32'h0, 0, 1, 0);
        check_out("retire", 32'd0, 1'b0, 1'b0);
        step(0, 0, 32'h0, 1, 0, 0);
        check_out("refill", 32'd0, 1'b0, c_REC);
        async_reset("rst3");

        // Simultaneous fetch+retire at occupancy 3, then flush with push.
        step(1, 0, 32'h11, 1, 0, 0);
        step(1, 0, 32'h22, 1, 0, 0);
        step(1, 0, 32'h33, 1, 0, 0);
        step(1, 0, 32'h44, 1, 1, 0);
        check_out("fetch_retire", 32'h44, 1'b1, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            step(0, 0, 32'h0, 1, 0, 0);
            if (k >= 4) begin
                check($sformatf("occ%0d track_full", k + 3), {31'd0, bus_if.track_full},
                      {31'd0, (k == 5) ? c_REC : 1'b0});
            end
        end
        step(1, 0, 32'h300, 0, 0, 1);
        check_out("flush_push", c_REC ? 32'h22 : 32'h300, 1'b1, 1'b0);
        step(0, 1, 32'h0, 0, 0, 0);
        check_out("after_flush_pop", c_REC ? 32'h11 : 32'h44, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/return_address_stack.md
# return_address_stack

Return address stack (RAS) for the fetch-stage branch predictor. It pushes return addresses on predicted calls and supplies the predicted target on predicted returns. It checkpoints its stack pointer for every predicted control-flow instruction that fetch issues. When the branch unit resolves a branch it either retires that checkpoint or, on a misprediction flush, restores the pointer from it. The block sits between fetch (push/pop/branch_fetched) and the branch unit (branch_retired, flush).

## Interface
- DEPTH, 8: stack entries; power of two, at least 2.
- TRACK_DEPTH, 8: maximum in-flight predicted instructions held in the checkpoint FIFO; power of two.
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- push  in  1  fetch predicts a call this cycle.
- pop  in  1  fetch predicts a return this cycle.
- new_addr  in  32  return address to push (call pc + 4).
- branch_fetched  in  1  fetch issued an instruction that used a prediction; record a checkpoint.
- branch_retired  in  1  branch unit completed the oldest predicted instruction without flush.
- flush  in  1  branch unit misprediction flush (branch_flush).
- addr  out  32  top-of-stack prediction; 0 when the stack is empty.
- valid  out  1  stack non-empty (count != 0).
- track_full  out  1  checkpoint FIFO full; fetch must not assert branch_fetched.

## Operation
- State:
  - stack[DEPTH] × 32, not reset.
  - read_index (log2 DEPTH bits), points at the top entry.
  - count, 0..DEPTH.
  - Checkpoint FIFO of {read_index, count}, TRACK_DEPTH deep.
- Per-cycle pointer update, with flush = 0:
  - push only: read_index+1 (wraps modulo DEPTH); stack[read_index+1] <= new_addr; count saturating-increments at DEPTH. When count is DEPTH, the oldest entry is overwritten (circular).
  - pop only: if count != 0, read_index-1 (wraps) and count-1. If count is 0, no change.
  - push and pop together (return-and-call):
    - count != 0: stack[read_index] <= new_addr; read_index and count unchanged.
    - count == 0: behaves as push only.
- Checkpoints:
  - On branch_fetched, the FIFO records the post-update {read_index, count}, i.e. the values after this cycle's push/pop.
  - On branch_retired, the head entry is discarded; this is ignored if the FIFO is empty.
  - branch_fetched and branch_retired in the same cycle: both take effect, and occupancy is unchanged.
- Flush:
  - read_index and count load the FIFO head checkpoint, which belongs to the flushing instruction. If the FIFO is empty, they hold their values.
  - The FIFO is then cleared.
  - push, pop, branch_fetched and branch_retired in the same cycle are ignored.
  - Stack contents are never restored; entries overwritten speculatively stay lost.
- branch_fetched while track_full: the request is dropped and state is unchanged; a simulation assertion fires.
- addr = (count != 0) ? stack[read_index] : 0. It reads the stack combinationally from registered state.

## Timing
- Reset values:
  - read_index 0, count 0, FIFO empty.
  - Outputs: addr 0, valid 0, track_full 0.
  - Reset mid-operation drops all state immediately (asynchronous).
- A push or pop is visible on addr/valid the next cycle; there is no same-cycle bypass.
- A flush restore is visible on addr/valid the next cycle.
- track_full is registered from occupancy. A retire makes it deassert the next cycle.
- Throughput: one push/pop/fetch record per cycle; zero stall cycles except when track_full is asserted.

## Configuration
- RAS_FLUSH_RECOVERY_EN defined: checkpoint FIFO, flush restore and track_full are implemented as above.
- Undefined:
  - No FIFO is built.
  - branch_fetched, branch_retired and flush are ignored; the pointer is never restored.
  - track_full is tied to 0.

## Test plan
- Reset, then push new_addr=0x100, then push 0x200 → addr 0x200, valid 1. Pop → addr 0x100. Pop → addr 0, valid 0. A further pop leaves count at 0.
- DEPTH=8: push 0x10..0x90 (9 values), then pop 8 times → addr sequence 0x90, 0x80 … 0x20, then valid 0. 0x10 was overwritten.
- Push 0x100 and pop together on a non-empty stack whose top is 0x50 → addr 0x100, count unchanged.
- Push 0x100 with branch_fetched (checkpoint index 1, count 1), then two more pushes with branch_fetched, then flush → addr 0x100, count 1, FIFO empty, track_full 0.
- 8 × branch_fetched with no retire → track_full 1. A 9th branch_fetched is dropped (assertion fires). One branch_retired → track_full 0 the next cycle.
- branch_retired and branch_fetched in the same cycle at occupancy 3 → occupancy stays 3. Flush together with push 0x300 → push ignored and pointer restored from the head checkpoint.
